// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control FSM for the JZJCoreF datapath.
// Sequences fetch/execute and memory handshakes, retires instructions, and
// latches a sticky halt cause.
// Ports:
//   clock, reset (async, active-low)
//   opcode, funct3, sysImm0        current instruction fields
//   errFlags[NUM_ERR]              datapath error flags
//   memAck / memReq, memWrite      memory controller handshake
//   rdWriteEnable, rdSource        register file write control
//   pcWriteEnable, fetchNext       PC control
//   retired, instret               retire pulse and registered count
//   halted, haltCause              registered halt status / sticky cause
module control_sequencer #(
  parameter int unsigned NUM_ERR       = 4,
  parameter int unsigned MIN_WAIT      = 1,
  parameter int unsigned MEM_TIMEOUT   = 15,
  parameter int unsigned SW_FAST       = 1,
  parameter int unsigned HALT_ON_ECALL = 1,
  parameter int unsigned INSTRET_W     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 sysImm0,
  input  logic [NUM_ERR-1:0]   errFlags,
  input  logic                 memAck,
  output logic                 memReq,
  output logic                 memWrite,
  output logic                 rdWriteEnable,
  output logic [1:0]           rdSource,
  output logic                 pcWriteEnable,
  output logic                 fetchNext,
  output logic                 retired,
  output logic [INSTRET_W-1:0] instret,
  output logic                 halted,
  output logic [3:0]           haltCause
);

  localparam logic [2:0] StResetWait = 3'd0;
  localparam logic [2:0] StInitFetch = 3'd1;
  localparam logic [2:0] StFetchExec = 3'd2;
  localparam logic [2:0] StMemWait   = 3'd3;
  localparam logic [2:0] StHalt      = 3'd4;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] MinWaitM1 = CntW'(MIN_WAIT - 1);
  // Only meaningful when MEM_TIMEOUT != 0; the compare is gated on that.
  localparam logic [CntW-1:0] TimeoutM1 = CntW'(MEM_TIMEOUT - 1);

  logic [2:0]           state_q, state_d;
  logic [CntW-1:0]      wait_cnt_q, wait_cnt_d;
  logic                 store_q, store_d;
  logic [INSTRET_W-1:0] instret_q;
  logic                 halted_q;
  logic [3:0]           halt_cause_q;

  logic                 halt_now;
  logic [3:0]           halt_cause_now;

  // Instruction decode
  logic       dec_single, dec_mem, dec_store, dec_rd_we;
  logic [1:0] dec_src;
  logic [3:0] dec_cause;  // non-zero: this instruction halts the core

  always_comb begin
    dec_single = 1'b0;
    dec_mem    = 1'b0;
    dec_store  = 1'b0;
    dec_rd_we  = 1'b0;
    dec_src    = 2'd0;
    dec_cause  = 4'd0;
    unique case (opcode)
      OpLui, OpAuipc: begin dec_single = 1'b1; dec_rd_we = 1'b1; dec_src = 2'd1; end
      OpJal, OpJalr:  begin dec_single = 1'b1; dec_rd_we = 1'b1; dec_src = 2'd2; end
      OpImm, OpReg:   begin dec_single = 1'b1; dec_rd_we = 1'b1; dec_src = 2'd0; end
      OpBranch, OpFence: dec_single = 1'b1;
      OpLoad:  dec_mem = 1'b1;
      OpStore: begin dec_mem = 1'b1; dec_store = 1'b1; end
      OpSystem: begin
        if (funct3 != 3'b000)      dec_cause = 4'd1;
        else if (sysImm0)          dec_cause = 4'd2;
        else if (HALT_ON_ECALL != 0) dec_cause = 4'd3;
        else                       dec_single = 1'b1;
      end
      default: dec_cause = 4'd1;
    endcase
  end

  // Lowest-index asserted error flag wins.
  logic [3:0] err_cause;
  logic       err_any;
  always_comb begin
    err_cause = 4'd0;
    for (int i = int'(NUM_ERR) - 1; i >= 0; i--) begin
      if (errFlags[i]) err_cause = 4'(8 + i);
    end
    err_any = |errFlags;
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    store_d        = store_q;
    halt_now       = 1'b0;
    halt_cause_now = halt_cause_q;
    memReq         = 1'b0;
    memWrite       = 1'b0;
    rdWriteEnable  = 1'b0;
    rdSource       = 2'd0;
    pcWriteEnable  = 1'b0;
    fetchNext      = 1'b0;
    retired        = 1'b0;
    case (state_q)
      StResetWait: state_d = StInitFetch;
      StInitFetch: state_d = StFetchExec;
      StFetchExec: begin
        if (err_any) begin
          halt_now = 1'b1; halt_cause_now = err_cause;
        end else if (dec_cause != 4'd0) begin
          halt_now = 1'b1; halt_cause_now = dec_cause;
        end else if (dec_single) begin
          pcWriteEnable = 1'b1;
          fetchNext     = 1'b1;
          retired       = 1'b1;
          rdWriteEnable = dec_rd_we;
          rdSource      = dec_src;
        end else if (dec_mem) begin
          memReq   = 1'b1;
          memWrite = dec_store;
          if (dec_store && funct3 == 3'b010 && SW_FAST != 0) begin
            // Fire-and-forget store: retires now, memAck is not awaited.
            pcWriteEnable = 1'b1;
            fetchNext     = 1'b1;
            retired       = 1'b1;
          end else begin
            wait_cnt_d = '0;
            store_d    = dec_store;
            state_d    = StMemWait;
          end
        end
      end
      StMemWait: begin
        memReq   = 1'b1;
        memWrite = store_q;
        if (err_any) begin
          halt_now = 1'b1; halt_cause_now = err_cause;
        end else if (memAck && wait_cnt_q >= MinWaitM1) begin
          pcWriteEnable = 1'b1;
          fetchNext     = 1'b1;
          retired       = 1'b1;
          rdWriteEnable = !store_q;
          rdSource      = store_q ? 2'd0 : 2'd3;
          state_d       = StFetchExec;
        end else if (MEM_TIMEOUT != 0 && wait_cnt_q == TimeoutM1) begin
          halt_now = 1'b1; halt_cause_now = 4'd4;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      StHalt: ;
      default: begin
        halt_now = 1'b1; halt_cause_now = 4'd5;
      end
    endcase
    if (halt_now) state_d = StHalt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StResetWait;
      wait_cnt_q   <= '0;
      store_q      <= 1'b0;
      instret_q    <= '0;
      halted_q     <= 1'b0;
      halt_cause_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      store_q    <= store_d;
      if (retired) instret_q <= instret_q + INSTRET_W'(1);
      if (halt_now) begin
        halted_q     <= 1'b1;
        halt_cause_q <= halt_cause_now;
      end
    end
  end

  assign instret   = instret_q;
  assign halted    = halted_q;
  assign haltCause = halt_cause_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic       clock = 1'b0;
  logic       rst_a, rst_b;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       sysImm0;
  logic [3:0] errFlags;
  logic       memAck;

  logic        memReq_a, memWrite_a, rdWE_a, pcWE_a, fetchNext_a, retired_a, halted_a;
  logic [1:0]  rdSource_a;
  logic [31:0] instret_a;
  logic [3:0]  haltCause_a;

  logic        memReq_b, memWrite_b, rdWE_b, pcWE_b, fetchNext_b, retired_b, halted_b;
  logic [1:0]  rdSource_b;
  logic [3:0]  instret_b;
  logic [3:0]  haltCause_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  control_sequencer #(
    .NUM_ERR(4), .MIN_WAIT(3), .MEM_TIMEOUT(15), .SW_FAST(1), .HALT_ON_ECALL(1), .INSTRET_W(32)
  ) dut_a (
    .clock(clock), .reset(rst_a), .opcode(opcode), .funct3(funct3), .sysImm0(sysImm0),
    .errFlags(errFlags), .memAck(memAck), .memReq(memReq_a), .memWrite(memWrite_a),
    .rdWriteEnable(rdWE_a), .rdSource(rdSource_a), .pcWriteEnable(pcWE_a),
    .fetchNext(fetchNext_a), .retired(retired_a), .instret(instret_a), .halted(halted_a),
    .haltCause(haltCause_a)
  );

  control_sequencer #(
    .NUM_ERR(4), .MIN_WAIT(1), .MEM_TIMEOUT(0), .SW_FAST(1), .HALT_ON_ECALL(0), .INSTRET_W(4)
  ) dut_b (
    .clock(clock), .reset(rst_b), .opcode(opcode), .funct3(funct3), .sysImm0(sysImm0),
    .errFlags(errFlags), .memAck(memAck), .memReq(memReq_b), .memWrite(memWrite_b),
    .rdWriteEnable(rdWE_b), .rdSource(rdSource_b), .pcWriteEnable(pcWE_b),
    .fetchNext(fetchNext_b), .retired(retired_b), .instret(instret_b), .halted(halted_b),
    .haltCause(haltCause_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse reset on dut_a, leaving it in FETCH_EXEC at a falling edge.
  task automatic restart_a();
    rst_a = 1'b0;
    @(negedge clock);
    rst_a = 1'b1;
    @(negedge clock);
    @(negedge clock);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    opcode = OpImm; funct3 = 3'd0; sysImm0 = 1'b0; errFlags = 4'd0; memAck = 1'b0;
    repeat (2) @(negedge clock);

    // Reset release, OP-IMM stream
    rst_a = 1'b1;
    #1;
    chk("rst_memReq", 32'(memReq_a), 32'd0);
    chk("rst_pcWE", 32'(pcWE_a), 32'd0);
    chk("rst_fetchNext", 32'(fetchNext_a), 32'd0);
    chk("rst_instret", instret_a, 32'd0);
    chk("rst_halted", 32'(halted_a), 32'd0);
    chk("rst_cause", 32'(haltCause_a), 32'd0);
    @(negedge clock); #1;
    chk("init_pcWE", 32'(pcWE_a), 32'd0);
    chk("init_retired", 32'(retired_a), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      chk("opimm_pcWE", 32'(pcWE_a), 32'd1);
      chk("opimm_retired", 32'(retired_a), 32'd1);
    end
    chk("opimm_rdWE", 32'(rdWE_a), 32'd1);
    chk("opimm_rdSrc", 32'(rdSource_a), 32'd0);
    chk("opimm_fetchNext", 32'(fetchNext_a), 32'd1);

    @(negedge clock); opcode = OpLui; #1;
    chk("instret_5", instret_a, 32'd5);
    chk("lui_rdSrc", 32'(rdSource_a), 32'd1);
    chk("lui_rdWE", 32'(rdWE_a), 32'd1);
    @(negedge clock); opcode = OpJal; #1;
    chk("jal_rdSrc", 32'(rdSource_a), 32'd2);
    @(negedge clock); opcode = OpBranch; #1;
    chk("br_rdWE", 32'(rdWE_a), 32'd0);
    chk("br_pcWE", 32'(pcWE_a), 32'd1);

    // lw, MIN_WAIT=3, ack held from the first MEM_WAIT cycle
    @(negedge clock); opcode = OpLoad; funct3 = 3'b010; memAck = 1'b1; #1;
    chk("lw_req", 32'(memReq_a), 32'd1);
    chk("lw_write", 32'(memWrite_a), 32'd0);
    chk("lw_fe_retired", 32'(retired_a), 32'd0);
    chk("lw_fe_pcWE", 32'(pcWE_a), 32'd0);
    @(negedge clock); #1;
    chk("lw_w0_retired", 32'(retired_a), 32'd0);
    chk("lw_w0_req", 32'(memReq_a), 32'd1);
    @(negedge clock); #1;
    chk("lw_w1_retired", 32'(retired_a), 32'd0);
    @(negedge clock); #1;
    chk("lw_w2_retired", 32'(retired_a), 32'd1);
    chk("lw_w2_rdWE", 32'(rdWE_a), 32'd1);
    chk("lw_w2_rdSrc", 32'(rdSource_a), 32'd3);
    chk("lw_w2_pcWE", 32'(pcWE_a), 32'd1);

    // Fast sw
    @(negedge clock); opcode = OpStore; funct3 = 3'b010; memAck = 1'b0; #1;
    chk("sw_instret", instret_a, 32'd9);
    chk("sw_req", 32'(memReq_a), 32'd1);
    chk("sw_write", 32'(memWrite_a), 32'd1);
    chk("sw_retired", 32'(retired_a), 32'd1);
    chk("sw_pcWE", 32'(pcWE_a), 32'd1);

    // sb without ack -> timeout
    @(negedge clock); funct3 = 3'b000; #1;
    chk("sb_req", 32'(memReq_a), 32'd1);
    chk("sb_retired", 32'(retired_a), 32'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clock); #1;
      if (i == 0 || i == 13) chk("sb_wait_req", 32'(memReq_a), 32'd1);
      chk("sb_wait_retired", 32'(retired_a), 32'd0);
      chk("sb_wait_halted", 32'(halted_a), 32'd0);
    end
    @(negedge clock); #1;
    chk("to_halted", 32'(halted_a), 32'd1);
    chk("to_cause", 32'(haltCause_a), 32'd4);
    chk("to_req", 32'(memReq_a), 32'd0);
    chk("to_instret", instret_a, 32'd10);
    rst_a = 1'b0; #1;
    chk("arst_halted", 32'(halted_a), 32'd0);
    chk("arst_cause", 32'(haltCause_a), 32'd0);
    chk("arst_instret", instret_a, 32'd0);

    // Error flags during jal
    restart_a();
    opcode = OpJal; errFlags = 4'b0110; #1;
    chk("err_retired", 32'(retired_a), 32'd0);
    chk("err_pcWE", 32'(pcWE_a), 32'd0);
    chk("err_rdWE", 32'(rdWE_a), 32'd0);
    @(negedge clock); errFlags = 4'b0001; #1;
    chk("err_halted", 32'(halted_a), 32'd1);
    chk("err_cause", 32'(haltCause_a), 32'd9);
    @(negedge clock); #1;
    chk("err_cause_sticky", 32'(haltCause_a), 32'd9);
    chk("err_halt_pcWE", 32'(pcWE_a), 32'd0);
    errFlags = 4'd0;

    // ebreak, ecall (halting), bad opcode
    restart_a();
    opcode = OpSystem; funct3 = 3'b000; sysImm0 = 1'b1; #1;
    chk("ebreak_retired", 32'(retired_a), 32'd0);
    @(negedge clock); #1;
    chk("ebreak_cause", 32'(haltCause_a), 32'd2);
    restart_a();
    sysImm0 = 1'b0; #1;
    chk("ecall_a_retired", 32'(retired_a), 32'd0);
    @(negedge clock); #1;
    chk("ecall_a_cause", 32'(haltCause_a), 32'd3);
    restart_a();
    opcode = 7'b0000000; #1;
    @(negedge clock); #1;
    chk("badop_cause", 32'(haltCause_a), 32'd1);

    // Reset in the middle of MEM_WAIT
    restart_a();
    opcode = OpLoad; funct3 = 3'b010; memAck = 1'b0; #1;
    @(negedge clock); #1;
    chk("mid_req", 32'(memReq_a), 32'd1);
    #2 rst_a = 1'b0; #1;
    chk("mid_rst_req", 32'(memReq_a), 32'd0);

    // dut_b: ecall retires, no timeout, 4-bit instret wrap
    @(negedge clock); rst_b = 1'b1;
    @(negedge clock);
    @(negedge clock);
    opcode = OpSystem; funct3 = 3'b000; sysImm0 = 1'b0; #1;
    chk("ecall_b_retired", 32'(retired_b), 32'd1);
    chk("ecall_b_rdWE", 32'(rdWE_b), 32'd0);
    chk("ecall_b_pcWE", 32'(pcWE_b), 32'd1);
    @(negedge clock); opcode = OpLoad; funct3 = 3'b010; memAck = 1'b0; #1;
    chk("b_lw_req", 32'(memReq_b), 32'd1);
    repeat (20) @(negedge clock);
    #1;
    chk("b_nto_halted", 32'(halted_b), 32'd0);
    chk("b_nto_req", 32'(memReq_b), 32'd1);
    chk("b_nto_retired", 32'(retired_b), 32'd0);
    @(negedge clock); memAck = 1'b1; #1;
    chk("b_lw_retired", 32'(retired_b), 32'd1);
    chk("b_lw_rdSrc", 32'(rdSource_b), 32'd3);
    @(negedge clock); memAck = 1'b0; opcode = OpImm; #1;
    chk("b_instret_2", 32'(instret_b), 32'd2);
    repeat (15) @(negedge clock);
    #1;
    chk("b_instret_wrap", 32'(instret_b), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
